rr_burst_scheduler: RTL and testbench
=====================================

// Module: rr_burst_scheduler
// PURPOSE
//  Shares one downstream valid/ready port among NUM_REQUESTERS burst sources.
//  Round-robin selection; the winner holds the port until its last beat or until MAX_BEATS.
//  Pass-through datapath with a registered grant.
//  Sits between per-thread/per-unit request queues and a single shared pipeline or memory port.
// PARAMETERS
//  NUM_REQUESTERS  4   number of requesters, >= 2
//  DATA_WIDTH      32  payload bits per beat
//  MAX_BEATS       8   max beats per grant before forced release, >= 1
//  BEAT_CNT_W      $clog2(MAX_BEATS+1)  derived width of the beat counter
//  ID_W            $clog2(NUM_REQUESTERS)  derived width of the source id
// PORTS
//  clk        in   1                  clock
//  rst_n      in   1                  reset; synchronous, active-low
//  req_valid  in   NUM_REQUESTERS     per-requester beat valid
//  req_data   in   N*DATA_WIDTH       flat payload; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//  req_last   in   NUM_REQUESTERS     per-requester last beat of burst
//  req_ready  out  NUM_REQUESTERS     per-requester beat accepted; one-hot or zero
//  out_valid  out  1                  downstream beat valid
//  out_data   out  DATA_WIDTH         downstream payload
//  out_last   out  1                  downstream last; also set on forced release
//  out_src    out  ID_W               index of the granted requester
//  out_ready  in   1                  downstream accepts the beat
//  busy       out  1                  1 while in LOCK
//  trunc_pls  out  1                  1-cycle pulse when a burst is cut at MAX_BEATS
// BEHAVIOUR
//  State
//   - state: IDLE/LOCK.
//   - prio_oh: one-hot rotating priority.
//   - grant_oh: one-hot grant register.
//   - beat_cnt counter.
//  Reset (rst_n=0 at clk edge)
//   - state=IDLE, prio_oh=1 (requester 0 first), grant_oh=0, beat_cnt=0.
//   - All outputs 0. Reset mid-burst abandons the burst; nothing is replayed.
//  IDLE
//   - out_valid=0, req_ready=0.
//   - If |req_valid: grant_oh <= first set bit of req_valid at or above prio_oh, wrapping N-1 -> 0.
//   - That same edge: state <= LOCK, beat_cnt <= 0.
//   - Arbitration costs exactly 1 idle cycle per grant.
//  LOCK, combinational pass-through of requester g (grant_oh)
//   - out_valid = req_valid[g]
//   - out_data = req_data[g]
//   - out_src = g
//   - out_last = req_last[g] | (beat_cnt == MAX_BEATS-1)
//   - req_ready = grant_oh & {N{out_ready}}
//   - busy = 1
//  Beat accept = out_valid & out_ready
//   - Increments beat_cnt.
//   - Other requesters' valid and data are ignored while locked.
//  Release, on an accepted beat with out_last=1
//   - state <= IDLE, grant_oh <= 0.
//   - prio_oh <= grant_oh rotated left by 1 (N-1 wraps to 0).
//   - If req_last[g]=0 at release (forced): trunc_pls=1 that cycle.
//   - After a forced release, the requester's remaining beats compete as a new burst.
//  Grant hold
//   - A granted requester dropping req_valid mid-burst keeps the grant.
//   - No timeout; out_valid=0 until it resumes.
//  Corner cases
//   - Single-beat burst (req_last=1 on first beat) occupies exactly 2 cycles: IDLE, LOCK.
//   - req_valid changing in the same cycle as IDLE arbitration: the sampled value wins.
//   - No new grant is issued in the release cycle; next arbitration is in the following IDLE cycle.
//  Invariants
//   - grant_oh and req_ready are one-hot or zero.
//   - beat_cnt never exceeds MAX_BEATS-1.
// TESTING
//  T1 reset: rst_n=0 for 2 clk, all req_valid=1
//     -> out_valid=0, req_ready=0, busy=0, trunc_pls=0 during reset.
//     -> 1st grant after release goes to requester 0.
//  T2 rotation: all 4 requesters hold 1-beat bursts, out_ready=1
//     -> out_src sequence 0,1,2,3,0; out_valid on every 2nd cycle.
//  T3 burst hold: req0 3-beat burst, req1 valid throughout
//     -> out_src=0 for 3 accepted beats, out_last only on beat 3, then out_src=1.
//  T4 truncation: MAX_BEATS=8, req2 sends 10 beats, last on beat 10
//     -> out_last and trunc_pls on beat 8; beats 9-10 go out after re-arbitration.
//  T5 backpressure: out_ready=0 for 5 cycles mid-burst
//     -> out_data stable, req_ready=0, beat_cnt frozen.
//     -> Source gaps req_valid for 3 cycles -> grant held.
//  T6 wrap and reset mid-burst
//     -> prio at req3, only req1 valid -> req1 granted.
//     -> rst_n pulsed mid-burst -> IDLE next cycle, prio back to req0.

Source files
------------

// File: rtl/rr_burst_scheduler.sv
// Round-robin burst scheduler: one requester at a time owns the downstream port
// until its last beat, or until MAX_BEATS beats forces a release.
module rr_burst_scheduler #(
   parameter int NUM_REQUESTERS = 4,
   parameter int DATA_WIDTH     = 32,
   parameter int MAX_BEATS      = 8,
   parameter int BEAT_CNT_W     = $clog2(MAX_BEATS + 1),
   parameter int ID_W           = $clog2(NUM_REQUESTERS)
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [NUM_REQUESTERS-1:0]            req_valid,
   input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQUESTERS-1:0]            req_last,
   output logic [NUM_REQUESTERS-1:0]            req_ready,
   output logic                                 out_valid,
   output logic [DATA_WIDTH-1:0]                out_data,
   output logic                                 out_last,
   output logic [ID_W-1:0]                      out_src,
   input  logic                                 out_ready,
   output logic                                 busy,
   output logic                                 trunc_pls
);

   localparam int N = NUM_REQUESTERS;

   typedef enum logic {IDLE, LOCK} state_t;

   state_t                state;
   logic [N-1:0]          prio_oh;
   logic [N-1:0]          grant_oh;
   logic [BEAT_CNT_W-1:0] beat_cnt;

   logic [N-1:0]          hi_req;
   logic [N-1:0]          base_req;
   logic [N-1:0]          pick_oh;
   logic [ID_W-1:0]       grant_idx;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  sel_valid;
   logic                  sel_last;
   logic                  lock;
   logic                  cap;
   logic                  accept;

   // Requests at or above the priority pointer win; otherwise wrap to the lowest index.
   always_comb begin
      hi_req   = req_valid & ~(prio_oh - N'(1));
      base_req = (|hi_req) ? hi_req : req_valid;
      pick_oh  = base_req & (~base_req + N'(1));
   end

   always_comb begin
      grant_idx = '0;
      sel_data  = '0;
      for (int i = 0; i < N; i++) begin
         if (grant_oh[i]) begin
            grant_idx = ID_W'(i);
            sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign sel_valid = |(req_valid & grant_oh);
   assign sel_last  = |(req_last & grant_oh);
   assign lock      = (state == LOCK);
   assign cap       = (beat_cnt == BEAT_CNT_W'(MAX_BEATS - 1));

   always_comb begin
      out_valid = lock & sel_valid;
      out_data  = lock ? sel_data : '0;
      out_src   = lock ? grant_idx : '0;
      out_last  = lock & (sel_last | cap);
      req_ready = grant_oh & {N{out_ready & lock}};
      busy      = lock;
      accept    = out_valid & out_ready;
      trunc_pls = accept & out_last & ~sel_last;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         prio_oh  <= N'(1);
         grant_oh <= '0;
         beat_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               beat_cnt <= '0;
               if (|req_valid) begin
                  grant_oh <= pick_oh;
                  state    <= LOCK;
               end
            end
            LOCK: begin
               if (accept) begin
                  if (out_last) begin
                     state    <= IDLE;
                     grant_oh <= '0;
                     prio_oh  <= {grant_oh[N-2:0], grant_oh[N-1]};
                     beat_cnt <= '0;
                  end else begin
                     beat_cnt <= beat_cnt + BEAT_CNT_W'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rr_burst_scheduler.sv
// Bench for rr_burst_scheduler: directed scenarios then randomized traffic, all
// checked every cycle against a transaction-level arbitration model.
module tb_rr_burst_scheduler;

   localparam int NR  = 4;
   localparam int DW  = 32;
   localparam int MB  = 8;
   localparam int IDW = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [NR-1:0]    req_valid;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0]    req_last;
   logic [NR-1:0]    req_ready;
   logic             out_valid;
   logic [DW-1:0]    out_data;
   logic             out_last;
   logic [IDW-1:0]   out_src;
   logic             out_ready;
   logic             busy;
   logic             trunc_pls;

   always #5 clk = ~clk;

   rr_burst_scheduler #(
      .NUM_REQUESTERS(NR), .DATA_WIDTH(DW), .MAX_BEATS(MB)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
      .req_ready(req_ready),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
      .out_src(out_src), .out_ready(out_ready),
      .busy(busy), .trunc_pls(trunc_pls)
   );

   int tests = 0;
   int fails = 0;

   // Per-source pending beats: {last, data}
   logic [DW:0] src_q[NR][$];
   logic [NR-1:0] gap = '0;
   bit   rand_mode = 1'b0;
   logic ready_cfg = 1'b1;

   int lg_src[$];
   bit lg_last[$];
   bit lg_trunc[$];

   // Reference model: who owns the port, rotating priority, beats sent in this grant
   bit m_lock = 1'b0;
   int m_prio = 0;
   int m_g    = 0;
   int m_cnt  = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit pending();
      for (int i = 0; i < NR; i++) if (src_q[i].size() > 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic load_burst(input int i, input int n);
      logic [DW:0] b;
      for (int k = 0; k < n; k++) begin
         b[DW]     = (k == n - 1);
         b[DW-1:0] = $urandom;
         src_q[i].push_back(b);
      end
   endtask

   task automatic clear_log();
      lg_src.delete();
      lg_last.delete();
      lg_trunc.delete();
   endtask

   task automatic drive();
      for (int i = 0; i < NR; i++) begin
         if (src_q[i].size() > 0) begin
            req_valid[i] = !gap[i] && (!rand_mode || $urandom_range(0, 3) != 0);
            req_data[i*DW +: DW] = src_q[i][0][DW-1:0];
            req_last[i] = src_q[i][0][DW];
         end else begin
            req_valid[i] = 1'b0;
            req_data[i*DW +: DW] = $urandom;
            req_last[i] = 1'($urandom_range(0, 1));
         end
      end
      out_ready = rand_mode ? ($urandom_range(0, 3) != 0) : ready_cfg;
   endtask

   task automatic cycle();
      logic          e_v, e_l, e_t, e_b;
      logic [DW-1:0] e_d;
      logic [NR-1:0] e_r;
      int            e_s;
      int            j;
      drive();
      @(negedge clk);
      e_v = 0; e_l = 0; e_t = 0; e_b = 0; e_d = '0; e_r = '0; e_s = 0;
      if (m_lock) begin
         e_v = req_valid[m_g];
         e_d = req_data[m_g*DW +: DW];
         e_s = m_g;
         e_l = req_last[m_g] || (m_cnt == MB - 1);
         e_r = out_ready ? (NR'(1) << m_g) : '0;
         e_b = 1'b1;
         e_t = e_v && out_ready && e_l && !req_last[m_g];
      end
      chk("out_valid", out_valid, e_v);
      chk("out_data",  out_data,  e_d);
      chk("out_src",   out_src,   e_s);
      chk("out_last",  out_last,  e_l);
      chk("req_ready", req_ready, e_r);
      chk("busy",      busy,      e_b);
      chk("trunc_pls", trunc_pls, e_t);
      if (out_valid && out_ready) begin
         lg_src.push_back(int'(out_src));
         lg_last.push_back(out_last);
         lg_trunc.push_back(trunc_pls);
      end
      for (int i = 0; i < NR; i++)
         if (rst_n && req_valid[i] && req_ready[i] && src_q[i].size() > 0)
            void'(src_q[i].pop_front());
      if (!rst_n) begin
         m_lock = 0; m_prio = 0; m_cnt = 0;
      end else if (!m_lock) begin
         for (int k = 0; k < NR; k++) begin
            j = (m_prio + k) % NR;
            if (!m_lock && req_valid[j]) begin
               m_lock = 1; m_g = j; m_cnt = 0;
            end
         end
      end else if (e_v && out_ready) begin
         if (e_l) begin
            m_lock = 0;
            m_prio = (m_g + 1) % NR;
         end else begin
            m_cnt++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_until_empty(input int budget);
      int n = 0;
      while (pending() && n < budget) begin
         cycle();
         n++;
      end
      chk("drain", pending(), 0);
      cycle();
   endtask

   initial begin
      drive();
      @(posedge clk);
      #1;

      // Reset with every requester asking, then single-beat rotation
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < NR; i++) load_burst(i, 1);
      rst_n = 1'b0;
      cycle();
      cycle();
      rst_n = 1'b1;
      clear_log();
      run_until_empty(100);
      chk("rot_count", lg_src.size(), 8);
      for (int k = 0; k < 8; k++) chk("rot_src", lg_src[k], k % NR);

      // Burst hold: req0 three beats while req1 waits
      clear_log();
      load_burst(0, 3);
      load_burst(1, 1);
      run_until_empty(100);
      chk("hold_count", lg_src.size(), 4);
      chk("hold_src0", lg_src[0], 0);
      chk("hold_src2", lg_src[2], 0);
      chk("hold_last1", lg_last[1], 0);
      chk("hold_last2", lg_last[2], 1);
      chk("hold_src3", lg_src[3], 1);

      // Truncation of a 10-beat burst at 8
      clear_log();
      load_burst(2, 10);
      run_until_empty(100);
      chk("trunc_count", lg_src.size(), 10);
      chk("trunc_last6", lg_last[6], 0);
      chk("trunc_last7", lg_last[7], 1);
      chk("trunc_pls7", lg_trunc[7], 1);
      chk("trunc_last9", lg_last[9], 1);
      chk("trunc_pls9", lg_trunc[9], 0);
      chk("trunc_src9", lg_src[9], 2);

      // Backpressure and source gap mid-burst
      clear_log();
      load_burst(1, 4);
      cycle();
      cycle();
      ready_cfg = 1'b0;
      repeat (5) cycle();
      ready_cfg = 1'b1;
      gap[1] = 1'b1;
      repeat (3) cycle();
      gap[1] = 1'b0;
      run_until_empty(100);
      chk("bp_count", lg_src.size(), 4);
      chk("bp_src3", lg_src[3], 1);
      chk("bp_last3", lg_last[3], 1);

      // Priority wrap, then reset mid-burst
      clear_log();
      load_burst(2, 1);
      run_until_empty(50);
      load_burst(1, 1);
      run_until_empty(50);
      chk("wrap_src", lg_src[1], 1);
      load_burst(3, 4);
      cycle();
      cycle();
      cycle();
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      for (int i = 0; i < NR; i++) src_q[i].delete();
      clear_log();
      load_burst(2, 1);
      load_burst(0, 1);
      run_until_empty(50);
      chk("rst_prio_src", lg_src[0], 0);

      // Randomized traffic with random gaps and backpressure
      rand_mode = 1'b1;
      for (int r = 0; r < 6; r++)
         for (int i = 0; i < NR; i++) load_burst(i, $urandom_range(1, 12));
      run_until_empty(4000);
      rand_mode = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
